// File: rtl/lock_dialer.sv
// Auto-dial sequencer for a combination lock: dials C1 clockwise, C2 counterclockwise,
// C3 clockwise, then waits for the lock to report open and flags done or fail.
module lock_dialer #(
  parameter int MSB     = 4,
  parameter int C1      = 12,
  parameter int C2      = 21,
  parameter int C3      = 15,
  parameter int TIMEOUT = 4,
  parameter int MAXSTEP = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [MSB:0] position,
  input  logic         open,
  output logic         up,
  output logic         down,
  output logic         busy,
  output logic         done,
  output logic         fail
);

  localparam int W  = MSB + 1;
  localparam int SW = $clog2(MAXSTEP + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [W-1:0]  C1_P     = W'(C1);
  localparam logic [W-1:0]  C2_P     = W'(C2);
  localparam logic [W-1:0]  C3_P     = W'(C3);
  localparam logic [SW-1:0] STEP_LAST = SW'(MAXSTEP - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    CW1   = 3'd2,
    CCW2  = 3'd3,
    CW3   = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6,
    FAIL  = 3'd7
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] step_cnt, step_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;

  // State and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      step_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state logic; step requests depend on the live position so dialing stops exactly on target
  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    wait_nxt  = wait_cnt;
    up        = 1'b0;
    down      = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          step_nxt  = '0;
          wait_nxt  = '0;
          state_nxt = (position == C1_P) ? PREP : CW1;
        end else begin
          state_nxt = state;
        end
      end
      PREP: begin
        // back off one notch so C1 is always reached by a clockwise move
        down      = 1'b1;
        state_nxt = CW1;
      end
      CW1: begin
        if (position != C1_P) begin
          up = 1'b1;
          if (step_cnt == STEP_LAST) state_nxt = FAIL;
          else                       step_nxt  = step_cnt + SW'(1);
        end else begin
          state_nxt = CCW2;
          step_nxt  = '0;
        end
      end
      CCW2: begin
        if (position != C2_P) begin
          down = 1'b1;
          if (step_cnt == STEP_LAST) state_nxt = FAIL;
          else                       step_nxt  = step_cnt + SW'(1);
        end else begin
          state_nxt = CW3;
          step_nxt  = '0;
        end
      end
      CW3: begin
        if (position != C3_P) begin
          up = 1'b1;
          if (step_cnt == STEP_LAST) state_nxt = FAIL;
          else                       step_nxt  = step_cnt + SW'(1);
        end else begin
          state_nxt = WAIT;
          wait_nxt  = '0;
        end
      end
      WAIT: begin
        if (open) begin
          state_nxt = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = FAIL;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = IDLE;
      step_nxt  = '0;
      wait_nxt  = '0;
    end else begin
      state_nxt = state_nxt;
    end
  end

  assign busy = (state == PREP) || (state == CW1) || (state == CCW2) ||
                (state == CW3)  || (state == WAIT);
  assign done = (state == DONE);
  assign fail = (state == FAIL);

endmodule

// File: tb/tb_lock_dialer.sv
// Randomized bench for lock_dialer: a behavioural lock drives position/open, a scoreboard
// holds expected per-sequence results and a negedge monitor compares when done/fail appears.
module tb_lock_dialer;

  localparam int MSB = 4, N = 32, C1 = 12, C2 = 21, C3 = 15, TIMEOUT = 4, MAXSTEP = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [MSB:0] position = '0;
  logic         open;
  logic         up, down, busy, done, fail;

  logic         load = 1'b0;
  logic [MSB:0] load_val = '0;
  logic         stuck = 1'b0;
  logic         open_en = 1'b0;
  int           open_delay = 2;
  int           stay = 0;

  typedef struct {
    bit ok;
    int ups;
    int downs;
    int cycles;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  lock_dialer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .position(position), .open(open),
    .up(up), .down(down), .busy(busy), .done(done), .fail(fail)
  );

  always #5 clock = ~clock;

  function automatic logic [MSB:0] lock_next(logic [MSB:0] p, logic u, logic d, logic s,
                                             logic ld, logic [MSB:0] lv);
    if (ld) return lv;
    if (s) return p;
    if (u) return p + 5'd1;
    if (d) return p - 5'd1;
    return p;
  endfunction

  // Lock model: position moves one step per request; open follows a dwell at C3
  always @(posedge clock) begin
    position <= lock_next(position, up, down, stuck, load, load_val);
    stay     <= (lock_next(position, up, down, stuck, load, load_val) == C3) ? stay + 1 : 0;
  end

  assign open = open_en && (stay >= open_delay);

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: step counts from modular distances along each phase's fixed direction
  function automatic exp_t model(int p0, bit en, int delay, bit stk);
    exp_t e;
    int p, s;
    e.ok = 1'b0; e.ups = 0; e.downs = 0; e.cycles = 0;
    if (stk) begin
      e.ups = MAXSTEP; e.cycles = MAXSTEP;
      return e;
    end
    p = p0;
    if (p == C1) begin
      e.downs = 1; e.cycles = 1; p = (p + N - 1) % N;
    end
    s = (C1 - p + N) % N;  e.ups   += s; e.cycles += s + 1;
    s = (C1 - C2 + N) % N; e.downs += s; e.cycles += s + 1;
    s = (C3 - C2 + N) % N; e.ups   += s; e.cycles += s + 1;
    if (en && delay <= TIMEOUT + 1) begin
      e.ok = 1'b1; e.cycles += delay - 1;
    end else begin
      e.cycles += TIMEOUT;
    end
    return e;
  endfunction

  int  m_ups = 0, m_downs = 0, m_cyc = 0;
  bit  m_both = 1'b0, prev_busy = 1'b0, prev_end = 1'b0;

  // Monitor: accumulate activity while busy, compare on the first cycle done/fail is shown
  always @(negedge clock) begin
    exp_t e;
    if (busy && !prev_busy) begin
      m_ups = 0; m_downs = 0; m_cyc = 0; m_both = 1'b0;
    end
    if (busy) begin
      m_cyc++;
      if (up) m_ups++;
      if (down) m_downs++;
      if (up && down) m_both = 1'b1;
    end
    if ((done || fail) && !prev_end) begin
      if (sb.size() == 0) begin
        check("unexpected_end", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_flag", int'(done), int'(e.ok));
        check("fail_flag", int'(fail), int'(!e.ok));
        check("up_cycles", m_ups, e.ups);
        check("down_cycles", m_downs, e.downs);
        check("busy_cycles", m_cyc, e.cycles);
        check("up_down_exclusive", int'(m_both), 0);
      end
    end
    prev_busy = busy;
    prev_end  = done || fail;
  end

  task automatic load_pos(int p);
    @(negedge clock);
    load = 1'b1; load_val = 5'(p);
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic run(int p0, bit en, int delay, bit stk, bit midstart);
    int k;
    load_pos(p0);
    open_en = en; open_delay = delay; stuck = stk;
    sb.push_back(model(p0, en, delay, stk));
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (!(done || fail) && k < 400) begin
      @(negedge clock);
      k++;
      start = (midstart && k == 10) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    if (k >= 400) check("sequence_timeout", k, 0);
    repeat (2) @(negedge clock);
    check("hold_up_down", int'(up || down), 0);
    check("hold_busy", int'(busy), 0);
    stuck = 1'b0;
  endtask

  initial begin
    int bad;
    repeat (2) @(negedge clock);
    check("rst_up", int'(up), 0);
    check("rst_down", int'(down), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fail", int'(fail), 0);
    reset = 1'b0;

    run(0, 1'b1, 2, 1'b0, 1'b0);
    run(12, 1'b1, 3, 1'b0, 1'b0);
    run(0, 1'b0, 2, 1'b0, 1'b0);
    run(5, 1'b1, 2, 1'b1, 1'b0);
    run(15, 1'b1, 5, 1'b0, 1'b1);
    run(21, 1'b1, 6, 1'b0, 1'b0);
    run(11, 1'b1, 4, 1'b0, 1'b1);

    // abort out of DONE clears the flag
    @(negedge clock); abort = 1'b1;
    @(posedge clock); #1;
    check("abort_clears_done", int'(done || fail), 0);
    @(negedge clock); abort = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
          int'($urandom_range(2, 6)), 1'b0, bit'($urandom_range(0, 1)));
    end

    // abort in the middle of CCW2
    load_pos(0);
    open_en = 1'b1; open_delay = 2;
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 100 && !down; i++) @(negedge clock);
    check("reach_ccw2", int'(down), 1);
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(posedge clock); #1;
    check("abort_up", int'(up), 0);
    check("abort_down", int'(down), 0);
    check("abort_busy", int'(busy), 0);
    @(negedge clock); abort = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_stays_idle", int'(busy || up || down || done || fail), 0);
    run(int'(position), 1'b1, 2, 1'b0, 1'b0);

    // asynchronous reset between edges during CW3
    load_pos(3);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 100 && !down; i++) @(negedge clock);
    for (int i = 0; i < 100 && !up; i++) @(negedge clock);
    check("reach_cw3", int'(up), 1);
    @(posedge clock); #3;
    check("cw3_up_before_reset", int'(up), 1);
    reset = 1'b1; #1;
    check("reset_drops_up", int'(up), 0);
    check("reset_drops_busy", int'(busy), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clock);
      if (up || down || busy || done || fail) bad++;
    end
    check("quiet_after_reset", bad, 0);
    run(int'(position), 1'b1, 3, 1'b0, 1'b0);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
